cc_pt_feeder: RTL
=================

// Module: cc_pt_feeder
// PURPOSE
//  Plaintext source for cc_encrypt. Takes a message length, then a 32-bit little-endian word
//  stream (valid/ready), and packs it into 512-bit blocks. Issues i_start to cc_encrypt and
//  answers each o_sig_pt request with one block on i_pt, qualified by an i_sig_pt pulse.
//  The final block is zero-padded beyond the message length.
// PARAMETERS
//  LEN_W   32  width of byte-length field; matches cc_encrypt i_len_pt
//  BLK_WD  16  32-bit words per block (fixed by ChaCha20; not to be changed)
// PORTS
//  i_clk      in   1    clock; all logic rising-edge
//  i_rst      in   1    reset, synchronous, active-high
//  i_cfg_vld  in   1    pulse: start new message, latch i_len (ignored unless IDLE)
//  i_len      in   32   message length in bytes
//  i_s_data   in   32   stream word; byte0 in [7:0]
//  i_s_vld    in   1    stream word valid
//  o_s_rdy    out  1    stream ready; word taken when i_s_vld & o_s_rdy
//  i_req      in   1    from cc_encrypt o_sig_pt: request next block (pulse)
//  o_start    out  1    to cc_encrypt i_start, 1-cycle pulse
//  o_len      out  32   to cc_encrypt i_len_pt, latched length
//  o_pt       out  512  to cc_encrypt i_pt; word k in [32k+31:32k]; held between updates
//  o_pt_vld   out  1    to cc_encrypt i_sig_pt, 1-cycle pulse, o_pt valid same cycle
//  o_busy     out  1    high from cfg accept until o_done
//  o_done     out  1    1-cycle pulse after last block handed over
//  o_err      out  1    sticky: request received while a request already pending
// BEHAVIOUR
//  Reset: all outputs 0, o_pt=0, o_len=0, state IDLE, counters/pending cleared; reset has
//   priority over all inputs and aborts any message in progress (no o_done).
//  Derived at cfg: nwd=ceil(len/4), nblk=ceil(len/64), tail=len%4; LEN_W-bit unsigned.
//  IDLE: o_s_rdy=0. i_cfg_vld & len!=0 -> latch len, o_busy=1, o_start pulse next cycle,
//   clear staging buffer, -> FILL. i_cfg_vld & len==0 -> o_done pulse next cycle, stay IDLE.
//  FILL: o_s_rdy=1 while words in staging block < want, want=min(16, nwd-16*blk). Accepted word
//   written at slot w_cnt; on the message's final word, bytes >= tail zeroed (tail!=0).
//   Unfilled slots stay 0. When w_cnt==want -> READY (o_s_rdy drops same edge).
//  READY: when pending|i_req: o_pt<=staging, o_pt_vld pulse next cycle, blk++, pending cleared;
//   if blk==nblk -> DONE else clear staging, w_cnt=0, -> FILL.
//  DONE: o_done pulse, o_busy=0, -> IDLE. One extra cycle, no stream accept.
//  Requests: i_req in FILL sets pending; served when block completes (o_pt_vld one cycle after
//   READY entry). i_req in READY served with 1-cycle latency. i_req while pending=1 -> o_err=1,
//   request dropped. i_req in IDLE/DONE ignored (no error).
//  o_pt changes only on the o_pt_vld cycle; stable otherwise (cc_encrypt samples at i_sig_pt).
//  i_cfg_vld when not IDLE ignored. Stream words in IDLE/READY/DONE not accepted (o_s_rdy=0).
//  Throughput: one word per cycle in FILL; no bubbles between accepted words.
// TESTING
//  Reset: assert i_rst 3 cycles mid-FILL -> all outputs 0 next cycle, no o_done, new cfg works.
//  RFC 8439 2.4.2: len=114, 29 words -> o_start once; nblk=2; 2nd o_pt word12=0x00002e74,
//   words13-15=0; cc_encrypt o_ct matches RFC ciphertext; o_done 1 cycle after 2nd o_pt_vld.
//  Exact block len=64: 16 words, one o_pt_vld, no padding; o_s_rdy never high after word 16.
//  Early request: i_req pulsed before any word -> o_pt_vld exactly 1 cycle after 16th accept.
//  Double request: two i_req pulses while FILL pending -> o_err=1 stays 1 until reset.
//  len=0 cfg -> o_done pulse next cycle, no o_start, o_s_rdy stays 0; len=5 -> 2 words, byte5+ 0.

Source files
------------

// File: rtl/cc_pt_feeder.sv
// Packs a little-endian 32-bit word stream into 512-bit ChaCha20 plaintext blocks for cc_encrypt.
// Each block is handed over one cycle after it is both complete and requested; the final block is zero-padded.
module cc_pt_feeder #(
  parameter int LEN_W  = 32,
  parameter int BLK_WD = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cfg_vld,
  input  logic [LEN_W-1:0]      i_len,
  input  logic [31:0]           i_s_data,
  input  logic                  i_s_vld,
  output logic                  o_s_rdy,
  input  logic                  i_req,
  output logic                  o_start,
  output logic [LEN_W-1:0]      o_len,
  output logic [BLK_WD*32-1:0]  o_pt,
  output logic                  o_pt_vld,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int WC_W = $clog2(BLK_WD);

  typedef enum logic [1:0] {IDLE, FILL, READY, DONE} state_t;

  state_t                  state_q;
  logic [WC_W-1:0]         w_cnt_q;
  logic [LEN_W-1:0]        rem_q;
  logic [1:0]              tail_q;
  logic                    pending_q;
  logic [BLK_WD-1:0][31:0] stg_q;

  logic [LEN_W-1:0]        nwd_d;
  logic [31:0]             word_d;
  logic                    take;
  logic                    last_word;
  logic                    blk_full;

  // rem_q counts words still to accept; staging-block capacity is tracked by w_cnt_q
  assign nwd_d     = (i_len >> 2) + LEN_W'(i_len[1:0] != 2'd0);
  assign o_s_rdy   = (state_q == FILL) && (rem_q != '0);
  assign take      = i_s_vld & o_s_rdy;
  assign last_word = (rem_q == LEN_W'(1));
  assign blk_full  = (w_cnt_q == WC_W'(BLK_WD - 1));

  always_comb begin
    word_d = i_s_data;
    if (last_word) begin
      case (tail_q)
        2'd1:    word_d = {24'd0, i_s_data[7:0]};
        2'd2:    word_d = {16'd0, i_s_data[15:0]};
        2'd3:    word_d = {8'd0,  i_s_data[23:0]};
        default: word_d = i_s_data;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      w_cnt_q   <= '0;
      rem_q     <= '0;
      tail_q    <= '0;
      pending_q <= 1'b0;
      stg_q     <= '0;
      o_start   <= 1'b0;
      o_len     <= '0;
      o_pt      <= '0;
      o_pt_vld  <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_start  <= 1'b0;
      o_pt_vld <= 1'b0;
      o_done   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_cfg_vld) begin
            if (i_len != '0) begin
              o_len     <= i_len;
              rem_q     <= nwd_d;
              tail_q    <= i_len[1:0];
              stg_q     <= '0;
              w_cnt_q   <= '0;
              pending_q <= 1'b0;
              o_busy    <= 1'b1;
              o_start   <= 1'b1;
              state_q   <= FILL;
            end else begin
              o_done <= 1'b1;
            end
          end
        end
        FILL: begin
          if (i_req) begin
            if (pending_q) o_err <= 1'b1;
            else           pending_q <= 1'b1;
          end
          if (take) begin
            stg_q[w_cnt_q] <= word_d;
            w_cnt_q        <= w_cnt_q + WC_W'(1);
            rem_q          <= rem_q - LEN_W'(1);
            if (last_word || blk_full) state_q <= READY;
          end
        end
        READY: begin
          if (i_req && pending_q) o_err <= 1'b1;
          if (pending_q || i_req) begin
            o_pt      <= stg_q;
            o_pt_vld  <= 1'b1;
            pending_q <= 1'b0;
            w_cnt_q   <= '0;
            if (rem_q == '0) begin
              state_q <= DONE;
            end else begin
              stg_q   <= '0;
              state_q <= FILL;
            end
          end
        end
        DONE: begin
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
